l2_burst_adapter: RTL and testbench
===================================

// Module: l2_burst_adapter
// PURPOSE
//  Bridges the L2 cache's 256-bit line interface (pmem_* side of L2 control) to the
//  64-bit burst physical memory port. A line read or write issued by the L2 is
//  serialized into BEATS burst transfers, then a single-cycle response returns to L2.
//  Sits directly downstream of the L2 cache datapath/control.
// PARAMETERS
//  ADDR_W   32   address width, both sides
//  BEAT_W   64   physical memory data width per beat
//  BEATS    4    beats per cache line; line width LINE_W = BEAT_W*BEATS (256)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  line_i     in   LINE_W  write line from L2 (valid while write_i high)
//  line_o     out  LINE_W  assembled read line to L2 (valid when resp_o high)
//  address_i  in   ADDR_W  line address from L2
//  read_i     in   1       L2 line-read request, held until resp_o
//  write_i    in   1       L2 line-write request, held until resp_o
//  resp_o     out  1       one-cycle completion pulse to L2
//  burst_i    in   BEAT_W  read beat from memory (valid when resp_i high)
//  burst_o    out  BEAT_W  write beat to memory
//  address_o  out  ADDR_W  line-aligned address to memory
//  read_o     out  1       memory burst-read request
//  write_o    out  1       memory burst-write request
//  resp_i     in   1       memory beat acknowledge, one per beat
// BEHAVIOUR
//  - States: IDLE, RD, WR, DONE. Beat counter cnt, $clog2(BEATS) bits.
//  - Reset: state=IDLE, cnt=0, line_o=0, resp_o=0, read_o=0, write_o=0, burst_o=0,
//    address_o=0. Reset mid-transfer aborts immediately; no resp_o issued.
//  - IDLE: if write_i -> latch line_i, address_i; cnt=0; go WR. Else if read_i ->
//    latch address_i; cnt=0; go RD. write_i has priority if both high. resp_i ignored.
//  - address_o = {latched addr[ADDR_W-1:5], 5'b0}; constant for whole transfer.
//  - RD: read_o=1. Each cycle resp_i=1: line_o[cnt*BEAT_W +: BEAT_W] <= burst_i,
//    cnt++. On beat BEATS-1 with resp_i -> DONE. Beat order low word first.
//  - WR: write_o=1, burst_o = latched_line[cnt*BEAT_W +: BEAT_W] combinationally.
//    Each resp_i advances cnt; on beat BEATS-1 with resp_i -> DONE.
//  - resp_i low in RD/WR: hold cnt, hold requests (wait states unbounded).
//  - DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, line_o stable; -> IDLE.
//  - Latency: request seen in IDLE cycle N; read_o/write_o high from N+1; with
//    zero-wait memory, resp_o at N+1+BEATS.
//  - line_o holds last assembled line until next read's first beat; unchanged by writes.
//  - cnt wraps to 0 after final beat; no request re-triggers in DONE (L2 drops its
//    request the cycle after resp_o; a request still high in IDLE starts a new op).
//  - Requests/address_i/line_i changes after acceptance are ignored until IDLE.
// TESTING
//  - Read, zero wait: read_i, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. ->
//    address_o=0x0000_1220, resp_o 5 cycles after accept, line_o={44,33,22,11} beats.
//  - Write, 2 wait cycles per beat: line_i=0xDDDD..CCCC..BBBB..AAAA -> burst_o AAAA,
//    BBBB, CCCC, DDDD in order; write_o high 12 cycles; single resp_o pulse.
//  - read_i and write_i both high in IDLE -> write performed, read_o never asserted.
//  - rst asserted after beat 2 of a read -> next cycle read_o=0, resp_o=0, state IDLE;
//    fresh read then completes with correct 4 beats.
//  - Stray resp_i in IDLE/DONE -> no state change, cnt stays 0, no resp_o.
//  - Back-to-back: read then write to 0xFFFF_FFE0 -> both complete, address_o aligned,
//    line_o retains read data through write.

Source files
------------

// File: rtl/l2_burst_adapter.sv
// l2_burst_adapter: serializes 256-bit L2 line reads/writes into 64-bit memory
// bursts and returns a single-cycle completion pulse to the L2.
module l2_burst_adapter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = 4,
    localparam int unsigned LINE_W = BEAT_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   wline_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                read_q;
    logic                write_q;
    logic                resp_q;
    logic [BEAT_W-1:0]   burst_d;
    logic                last_beat;
    logic [ADDR_W-1:0]   addr_aligned;
    logic                unused_addr_bits;

    assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));
    assign addr_aligned     = {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign unused_addr_bits = ^address_i[OFF_W-1:0];

    // Beat counter advance, wrapping to zero after the final beat.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (last_beat) begin
            cnt_d = '0;
        end
    end

    // Write beat selected straight from the latched line; zero outside WR.
    always_comb begin
        burst_d = '0;
        if (state_q == WR) begin
            burst_d = wline_q[cnt_q*BEAT_W +: BEAT_W];
        end
    end

    // Transfer FSM with registered request/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wline_q <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= addr_aligned;
                        cnt_q   <= '0;
                        write_q <= 1'b1;
                        state_q <= WR;
                    end else if (read_i) begin
                        addr_q  <= addr_aligned;
                        cnt_q   <= '0;
                        read_q  <= 1'b1;
                        state_q <= RD;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_q[cnt_q*BEAT_W +: BEAT_W] <= burst_i;
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = line_q;
    assign resp_o    = resp_q;
    assign burst_o   = burst_d;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;

endmodule

// File: tb/tb_l2_burst_adapter.sv
// Directed bench for l2_burst_adapter: a table of line transactions with a
// cycle-exact memory responder, plus hand sequences for reset and stray acks.
module tb_l2_burst_adapter;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = BEAT_W * BEATS;

    logic              clk = 1'b0;
    logic              rst;
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    int nchecks = 0;
    int nerrors = 0;
    logic [LINE_W-1:0] last_rd = '0;

    typedef struct {
        logic              is_rd;
        logic              both;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        int                waits;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    l2_burst_adapter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Line read with `waits` idle cycles before each acked beat.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                           input int waits, input logic [ADDR_W-1:0] exp_addr);
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        step();
        address_i = ~addr;
        for (int b = 0; b < BEATS; b++) begin
            for (int w = 0; w <= waits; w++) begin
                resp_i  = (w == waits);
                burst_i = (w == waits) ? data[b*BEAT_W +: BEAT_W] : 64'hDEAD_BEEF_DEAD_BEEF;
                chk("rd_read_o", read_o, 1'b1);
                chk("rd_write_o", write_o, 1'b0);
                chk("rd_resp_o_early", resp_o, 1'b0);
                chk("rd_address_o", address_o, exp_addr);
                step();
            end
        end
        // DONE cycle: request still held, stray ack present
        resp_i  = 1'b1;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        chk("rd_resp_o", resp_o, 1'b1);
        chk("rd_read_o_done", read_o, 1'b0);
        chk("rd_line_o", line_o, data);
        step();
        read_i = 1'b0;
        resp_i = 1'b0;
        chk("rd_resp_o_pulse", resp_o, 1'b0);
        chk("rd_read_o_idle", read_o, 1'b0);
        chk("rd_line_o_hold", line_o, data);
        last_rd = data;
    endtask

    // Line write; `both` also raises read_i, which must lose to the write.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                            input int waits, input logic both, input logic [ADDR_W-1:0] exp_addr);
        int wcnt;
        wcnt      = 0;
        write_i   = 1'b1;
        read_i    = both;
        address_i = addr;
        line_i    = data;
        step();
        address_i = ~addr;
        line_i    = ~data;
        for (int b = 0; b < BEATS; b++) begin
            for (int w = 0; w <= waits; w++) begin
                resp_i  = (w == waits);
                burst_i = 64'h5A5A_5A5A_5A5A_5A5A;
                chk("wr_burst_o", burst_o, data[b*BEAT_W +: BEAT_W]);
                chk("wr_read_o", read_o, 1'b0);
                chk("wr_resp_o_early", resp_o, 1'b0);
                chk("wr_address_o", address_o, exp_addr);
                if (write_o) wcnt++;
                step();
            end
        end
        resp_i = 1'b1;
        chk("wr_resp_o", resp_o, 1'b1);
        chk("wr_write_o_done", write_o, 1'b0);
        chk("wr_read_o_done", read_o, 1'b0);
        chk("wr_write_o_cycles", wcnt, BEATS * (waits + 1));
        step();
        write_i = 1'b0;
        read_i  = 1'b0;
        resp_i  = 1'b0;
        chk("wr_resp_o_pulse", resp_o, 1'b0);
        chk("wr_write_o_idle", write_o, 1'b0);
        chk("wr_line_o_kept", line_o, last_rd);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 32'h0000_1220};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_2000,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 2, 32'h0000_2000};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_003F,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 1, 32'h0000_0020};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                    {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                     64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 32'hFFFF_FFE0};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFE0,
                    {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                     64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 0, 32'hFFFF_FFE0};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFE0,
                    {64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3,
                     64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1}, 0, 32'hFFFF_FFE0};

        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        step();
        step();
        chk("rst_line_o", line_o, '0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_burst_o", burst_o, '0);
        chk("rst_address_o", address_o, '0);
        rst = 1'b0;

        // Stray acknowledges in IDLE must not move the FSM
        resp_i  = 1'b1;
        burst_i = 64'hCAFE_CAFE_CAFE_CAFE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_stray_resp_o", resp_o, 1'b0);
            chk("idle_stray_read_o", read_o, 1'b0);
            chk("idle_stray_write_o", write_o, 1'b0);
            chk("idle_stray_line_o", line_o, '0);
        end
        resp_i = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_rd)
                do_read(vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].exp_addr);
            else
                do_write(vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].both, vecs[i].exp_addr);
        end

        // Reset after two beats of a read aborts without a response
        read_i    = 1'b1;
        address_i = 32'h0000_5678;
        step();
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'h7777_0000_0000_0000 | 64'(b);
            chk("abort_read_o", read_o, 1'b1);
            chk("abort_address_o", address_o, 32'h0000_5660);
            step();
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_read_o_rst", read_o, 1'b0);
        chk("abort_resp_o_rst", resp_o, 1'b0);
        chk("abort_line_o_rst", line_o, '0);
        chk("abort_address_o_rst", address_o, '0);
        step();
        chk("abort_read_o_idle", read_o, 1'b0);
        chk("abort_resp_o_idle", resp_o, 1'b0);
        last_rd = '0;
        do_read(32'h0000_5678,
                {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}, 0, 32'h0000_5660);

        step();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
